// File: rtl/apb_burst_master_if.sv
// rtl/apb_burst_master_if.sv - command, APB bus, status and interrupt signals of apb_burst_master
interface apb_burst_master_if #(
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = 5
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [4:0]         cmd_len;
  logic [MAX_LEN-1:0] cmd_wdata;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [ADDR_W-1:0]  paddr;
  logic               pwdata;
  logic               prdata;
  logic               int_b;
  logic               busy;
  logic               done;
  logic [MAX_LEN-1:0] rdata;
  logic               irq;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, prdata, int_b,
    output cmd_ready, psel, penable, pwrite, paddr, pwdata, busy, done, rdata, irq
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, prdata, int_b,
    input  cmd_ready, psel, penable, pwrite, paddr, pwdata, busy, done, rdata, irq
  );
endinterface

// File: rtl/apb_burst_master.sv
// rtl/apb_burst_master.sv - APB burst initiator with INT_B synchronizer; optional macro APB_BURST_MASTER_INT_GATE_EN
module apb_burst_master #(
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = 5
) (
  input  logic               sysclk,
  input  logic               rst,
  apb_burst_master_if.master bus
);
  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, FINISH} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [4:0]         len_q, len_n, len_in;
  logic [4:0]         idx_q, idx_n;
  logic               wr_q, wr_n;
  logic [MAX_LEN-1:0] wdata_q, wdata_n;
  logic [MAX_LEN-1:0] shadow_q, shadow_n;
  logic [MAX_LEN-1:0] len_mask;

  logic               cmd_ready_q, cmd_ready_n;
  logic               psel_q, psel_n;
  logic               penable_q, penable_n;
  logic               pwrite_q, pwrite_n;
  logic [ADDR_W-1:0]  paddr_q, paddr_n;
  logic               pwdata_q, pwdata_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic [MAX_LEN-1:0] rdata_q, rdata_n;
  logic               int_sync_q;
  logic               irq_q;

  // Clamp the requested length and build the mask of bits a read burst actually filled
  always_comb begin
    len_in   = (bus.cmd_len > MAX_LEN_L) ? MAX_LEN_L : bus.cmd_len;
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (5'(i) < len_q);
    end
  end

  // Next-state and next-output logic; outputs are registered from the next-state values
  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    len_n    = len_q;
    idx_n    = idx_q;
    wr_n     = wr_q;
    wdata_n  = wdata_q;
    shadow_n = shadow_q;
    rdata_n  = rdata_q;

    case (state)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          addr_n  = bus.cmd_addr;
          len_n   = len_in;
          wr_n    = bus.cmd_write;
          wdata_n = bus.cmd_wdata;
          idx_n   = '0;
          state_n = (len_in == 5'd0) ? FINISH : SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (!wr_q) begin
          shadow_n[idx_q[IDX_W-1:0]] = bus.prdata;
        end
        idx_n   = idx_q + 5'd1;
        addr_n  = addr_q + ADDR_W'(1);
        state_n = (idx_n == len_q) ? FINISH : SETUP;
        // The last read bit is folded in on the same edge that enters FINISH
        if (state_n == FINISH && !wr_q) begin
          rdata_n = shadow_n & len_mask;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    psel_n    = (state_n == SETUP) || (state_n == ACCESS);
    penable_n = (state_n == ACCESS);
    busy_n    = (state_n != IDLE);
    done_n    = (state_n == FINISH);
    paddr_n   = (state_n == SETUP) ? addr_n : paddr_q;
    pwrite_n  = (state_n == SETUP) ? wr_n : pwrite_q;
    pwdata_n  = (state_n == SETUP) ? (wr_n & wdata_n[idx_n[IDX_W-1:0]]) : pwdata_q;
`ifdef APB_BURST_MASTER_INT_GATE_EN
    cmd_ready_n = (state_n == IDLE) && int_sync_q;
`else
    cmd_ready_n = (state_n == IDLE);
`endif
  end

  // State, burst context and registered outputs
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      shadow_q    <= '0;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      len_q       <= len_n;
      idx_q       <= idx_n;
      wr_q        <= wr_n;
      wdata_q     <= wdata_n;
      shadow_q    <= shadow_n;
      cmd_ready_q <= cmd_ready_n;
      psel_q      <= psel_n;
      penable_q   <= penable_n;
      pwrite_q    <= pwrite_n;
      paddr_q     <= paddr_n;
      pwdata_q    <= pwdata_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      rdata_q     <= rdata_n;
    end
  end

  // Two-flop synchronizer on the active-low interrupt; the second flop holds the inverted level
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      int_sync_q <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      int_sync_q <= bus.int_b;
      irq_q      <= ~int_sync_q;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.irq       = irq_q;
endmodule

// File: tb/tb_apb_burst_master.sv
// tb/tb_apb_burst_master.sv - directed self-checking bench for apb_burst_master
module tb_apb_burst_master;
  logic sysclk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic mem [32];

  always #5 sysclk = ~sysclk;

  apb_burst_master_if #(.MAX_LEN(16), .ADDR_W(5)) bus ();

  apb_burst_master #(.MAX_LEN(16), .ADDR_W(5)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus)
  );

  assign bus.prdata = mem[bus.paddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one burst and checks every phase; exp_rdata is RDATA expected from FINISH on
  task automatic run_burst(input logic wr, input logic [4:0] addr, input logic [4:0] len,
                           input logic [15:0] wdata, input logic [15:0] exp_rdata);
    int         n;
    logic [4:0] a;
    logic       d;
    n = (len > 5'd16) ? 16 : int'(len);
    @(negedge sysclk);
    check("ready_before", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_wdata = wdata;
    @(posedge sysclk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = ~wr;
    bus.cmd_addr  = ~addr;
    bus.cmd_len   = 5'd7;
    bus.cmd_wdata = ~wdata;
    for (int i = 0; i < n; i++) begin
      a = addr + 5'(i);
      d = wr & wdata[i];
      @(negedge sysclk);
      check("setup", 32'({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.busy, bus.done}),
            32'({1'b1, 1'b0, wr, a, d, 1'b1, 1'b0}));
      @(negedge sysclk);
      check("access", 32'({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.busy, bus.done}),
            32'({1'b1, 1'b1, wr, a, d, 1'b1, 1'b0}));
    end
    @(negedge sysclk);
    check("finish", 32'({bus.psel, bus.penable, bus.busy, bus.done, bus.cmd_ready}), 32'(5'b00110));
    check("rdata_done", 32'(bus.rdata), 32'(exp_rdata));
    @(negedge sysclk);
    check("idle", 32'({bus.psel, bus.busy, bus.done, bus.cmd_ready}), 32'(4'b0001));
    check("rdata_idle", 32'(bus.rdata), 32'(exp_rdata));
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_wdata = '0;
    bus.int_b     = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 1'b0;
    mem[30] = 1'b1;
    mem[31] = 1'b1;
    mem[0]  = 1'b0;
    mem[1]  = 1'b1;

    #12;
    check("reset_outputs", 32'({bus.cmd_ready, bus.psel, bus.penable, bus.pwrite, bus.paddr,
                                bus.pwdata, bus.busy, bus.done, bus.irq}), 32'd0);
    check("reset_rdata", 32'(bus.rdata), 32'd0);
    @(negedge sysclk);
    rst = 1'b0;
    @(posedge sysclk);
    #1;
    check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    // Read across the address wrap: bits from 1E,1F,00,01 = 1,1,0,1
    run_burst(1'b0, 5'h1E, 5'd4, 16'h0000, 16'h000B);
    // Short read: stale shadow bits at and above len must be cleared
    run_burst(1'b0, 5'h1E, 5'd2, 16'h0000, 16'h0003);
    // Write leaves RDATA unchanged
    run_burst(1'b1, 5'h02, 5'd3, 16'b101, 16'h0003);
    // Zero-length read: DONE one cycle after acceptance, RDATA unchanged
    run_burst(1'b0, 5'h05, 5'd0, 16'h0000, 16'h0003);
    // Oversized length clamps to 16 transfers, addresses 18..1F,00..07
    run_burst(1'b1, 5'h18, 5'd20, 16'hA5C3, 16'h0003);

    // Reset during the ACCESS phase of the second transfer of a 5-long write
    @(negedge sysclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 5'h04;
    bus.cmd_len   = 5'd5;
    bus.cmd_wdata = 16'h001F;
    @(posedge sysclk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge sysclk);
    check("mid_access", 32'({bus.psel, bus.penable, bus.paddr}), 32'({1'b1, 1'b1, 5'h05}));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_bus", 32'({bus.cmd_ready, bus.psel, bus.penable, bus.pwrite, bus.paddr,
                                bus.pwdata, bus.busy, bus.done, bus.irq}), 32'd0);
    check("rst_async_rdata", 32'(bus.rdata), 32'd0);
    @(negedge sysclk);
    rst = 1'b0;
    @(posedge sysclk);
    #1;
    check("post_rst_state", 32'({bus.cmd_ready, bus.busy, bus.done, bus.psel}), 32'(4'b1000));
    run_burst(1'b1, 5'h07, 5'd1, 16'h0001, 16'h0000);

    // Interrupt synchronizer latency and optional command gating
    @(negedge sysclk);
    bus.int_b = 1'b0;
    @(posedge sysclk);
    #1;
    check("irq_edge1", 32'(bus.irq), 32'd0);
    @(posedge sysclk);
    #1;
    check("irq_edge2", 32'(bus.irq), 32'd1);
`ifdef APB_BURST_MASTER_INT_GATE_EN
    check("ready_gated", 32'(bus.cmd_ready), 32'd0);
`else
    check("ready_ungated", 32'(bus.cmd_ready), 32'd1);
`endif
    @(negedge sysclk);
    bus.int_b = 1'b1;
    @(posedge sysclk);
    #1;
    check("irq_hold", 32'(bus.irq), 32'd1);
    @(posedge sysclk);
    #1;
    check("irq_clear", 32'(bus.irq), 32'd0);
    check("ready_irq_clear", 32'(bus.cmd_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
